move_sequencer: RTL and testbench
=================================

MOVE_SEQUENCER -- requirements
Module: move_sequencer

Interface
REQ-001 Parameter: TIMEOUT, default 16'd50000, IDLE cycles allowed per turn before forfeit; 0 disables the timeout.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 x_req  input  1  X player move request, level, sampled in IDLE only.
REQ-005 x_pos  input  4  X requested cell, 1..9.
REQ-006 o_req  input  1  O player move request, level, sampled in IDLE only.
REQ-007 o_pos  input  4  O requested cell, 1..9.
REQ-008 new_game  input  1  restart request, honoured in OVER only.
REQ-009 turn  input  1  board turn flag; 0 = X to move, 1 = O to move.
REQ-010 board_state  input  18  cell k (1..9) at bits [2k-1:2k-2]; 11 = X, 10 = O, 00 = empty; bit 2k-1 = occupied.
REQ-011 xwin, owin, tie  input  1 each  result flags derived from board_state.
REQ-012 position  output  4  move command to the board; 0 = no move.
REQ-013 board_clear  output  1  one-cycle pulse that clears the board, ORed into board reset.
REQ-014 x_ack, o_ack  output  1 each  one-cycle pulse: move accepted and committed.
REQ-015 x_rej, o_rej  output  1 each  one-cycle pulse: request refused.
REQ-016 move_err  output  1  one-cycle pulse: issued move not reflected by the board.
REQ-017 game_over  output  1  level, high in OVER.
REQ-018 winner  output  2  00 none, 01 X, 10 O, 11 tie; valid while game_over.
REQ-019 move_count  output  4  committed moves this game, 0..9.

Function
REQ-020 FSM states: IDLE, ISSUE, WAIT, CHECK, OVER, CLEAR.
REQ-021 IDLE: accept only the current player's request (X if turn=0, O if turn=1).
REQ-022 IDLE, current player's request valid (pos 1..9 and the cell's occupied bit 0): latch pos and mover, go to ISSUE.
REQ-023 IDLE, current player's request invalid (pos 0, pos >9, or cell occupied): pulse that player's rej, stay IDLE.
REQ-024 IDLE, request from the off-turn player: pulse that player's rej every cycle it is asserted, including when both players request in the same cycle.
REQ-025 ISSUE: drive position = latched pos for exactly one cycle; position = 0 in every other state.
REQ-026 WAIT: one cycle, lets the board register update and the result flags settle.
REQ-027 CHECK, turn differs from the latched mover's turn (move committed): pulse the mover's ack, increment move_count (saturate at 9).
REQ-028 CHECK, turn unchanged (move not committed): pulse move_err, no ack, no count change, return to IDLE.
REQ-029 CHECK, after a commit: xwin -> winner 01; else owin -> 10; else tie or move_count reaches 9 -> 11. Any of these goes to OVER; otherwise go to IDLE.
REQ-030 Latency: request seen in IDLE at cycle N -> position nonzero at N+1, ack at N+3, earliest next acceptance at N+4.
REQ-031 Turn timer: 16-bit, counts only in IDLE, cleared on every IDLE entry; holds while any request is being rejected.
REQ-032 Timer reaches TIMEOUT (TIMEOUT != 0): forfeit; winner = opponent of the current turn, go to OVER.
REQ-033 Timeout and a valid request in the same cycle: the request wins, no forfeit.
REQ-034 OVER: game_over = 1, winner held, all requests rejected with rej pulses.
REQ-035 OVER with new_game: go to CLEAR.
REQ-036 CLEAR: board_clear = 1 for one cycle; move_count, winner and timer cleared; go to IDLE.
REQ-037 Requests are not queued; a player must hold req until ack or rej.

Reset
REQ-038 reset asserted, any state including ISSUE/WAIT: state = IDLE, position = 0, board_clear = 0, all pulses 0, game_over = 0, winner = 00, move_count = 0, timer = 0, latched pos and mover = 0.
REQ-039 No pulse output is generated in the first cycle after reset deasserts.

Verification
REQ-040 turn=0, empty board, x_req=1, x_pos=5 at cycle N -> position=5 at N+1 only; x_ack at N+3; move_count=1.
REQ-041 turn=0, x_req with x_pos=5 on occupied cell 5 -> x_rej same cycle, position stays 0; with x_pos=0 or 10 -> x_rej same cycle.
REQ-042 x_req and o_req both asserted with turn=0 -> X proceeds, o_rej pulses, no o_ack.
REQ-043 X completes a row (cells 1,2,3) and xwin=1 in CHECK -> game_over=1, winner=01; later x_req -> x_rej; new_game -> board_clear for one cycle, then IDLE with move_count=0.
REQ-044 TIMEOUT=4, turn=1, no requests -> after 4 IDLE cycles game_over=1, winner=01; board not changed (turn stuck) after ISSUE -> move_err pulse, no ack.

Source files
------------

// File: rtl/move_sequencer.sv
// Tic-tac-toe move sequencer: arbitrates player requests, issues one-cycle move commands to the
// board, confirms commits via the turn flag, and tracks results, forfeits and restarts.
module move_sequencer #(
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        x_req,
  input  logic [3:0]  x_pos,
  input  logic        o_req,
  input  logic [3:0]  o_pos,
  input  logic        new_game,
  input  logic        turn,
  input  logic [17:0] board_state,
  input  logic        xwin,
  input  logic        owin,
  input  logic        tie,
  output logic [3:0]  position,
  output logic        board_clear,
  output logic        x_ack,
  output logic        o_ack,
  output logic        x_rej,
  output logic        o_rej,
  output logic        move_err,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic [3:0]  move_count
);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StCheck, StOver, StClear} state_e;

  state_e      state;
  logic        mover;
  logic [15:0] timer;
  logic        armed;

  logic        cur_req;
  logic [3:0]  cur_pos;
  logic        cur_blocked;
  logic        idle_live;
  logic        accept;
  logic        rejecting;
  logic        commit;
  logic        timeout_hit;
  logic [15:0] timer_inc;
  logic [3:0]  count_inc;
  logic        unused_cells;

  // Only the occupied bit of each cell matters here.
  assign unused_cells = ^{board_state[16], board_state[14], board_state[12], board_state[10],
                          board_state[8], board_state[6], board_state[4], board_state[2],
                          board_state[0]};

  assign cur_req = turn ? o_req : x_req;
  assign cur_pos = turn ? o_pos : x_pos;

  // Out-of-range positions fall into default and are treated like an occupied cell.
  always_comb begin
    cur_blocked = 1'b1;
    case (cur_pos)
      4'd1:    cur_blocked = board_state[1];
      4'd2:    cur_blocked = board_state[3];
      4'd3:    cur_blocked = board_state[5];
      4'd4:    cur_blocked = board_state[7];
      4'd5:    cur_blocked = board_state[9];
      4'd6:    cur_blocked = board_state[11];
      4'd7:    cur_blocked = board_state[13];
      4'd8:    cur_blocked = board_state[15];
      4'd9:    cur_blocked = board_state[17];
      default: cur_blocked = 1'b1;
    endcase
  end

  // armed stays low for the first cycle after reset so no pulse can appear there.
  assign idle_live = (state == StIdle) && armed;
  assign accept    = idle_live && cur_req && !cur_blocked;

  assign x_rej = (idle_live && x_req && (turn || cur_blocked)) || ((state == StOver) && x_req);
  assign o_rej = (idle_live && o_req && (!turn || cur_blocked)) || ((state == StOver) && o_req);
  assign rejecting = x_rej || o_rej;

  assign commit   = (state == StCheck) && (turn != mover);
  assign x_ack    = commit && !mover;
  assign o_ack    = commit && mover;
  assign move_err = (state == StCheck) && !commit;

  assign timer_inc   = timer + 16'd1;
  assign timeout_hit = (TIMEOUT != 16'd0) && (timer_inc == TIMEOUT);
  assign count_inc   = (move_count == 4'd9) ? 4'd9 : move_count + 4'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= StIdle;
      mover       <= 1'b0;
      timer       <= 16'd0;
      armed       <= 1'b0;
      position    <= 4'd0;
      board_clear <= 1'b0;
      game_over   <= 1'b0;
      winner      <= 2'b00;
      move_count  <= 4'd0;
    end else begin
      armed <= 1'b1;
      case (state)
        StIdle: begin
          if (accept) begin
            mover    <= turn;
            position <= cur_pos;
            state    <= StIssue;
          end else if (idle_live && !rejecting) begin
            if (timeout_hit) begin
              winner    <= turn ? 2'b01 : 2'b10;
              game_over <= 1'b1;
              state     <= StOver;
            end else begin
              timer <= timer_inc;
            end
          end
        end
        StIssue: begin
          position <= 4'd0;
          state    <= StWait;
        end
        StWait: state <= StCheck;
        StCheck: begin
          timer <= 16'd0;
          state <= StIdle;
          if (commit) begin
            move_count <= count_inc;
            if (xwin || owin || tie || (count_inc == 4'd9)) begin
              winner    <= xwin ? 2'b01 : (owin ? 2'b10 : 2'b11);
              game_over <= 1'b1;
              state     <= StOver;
            end
          end
        end
        StOver: begin
          if (new_game) begin
            game_over   <= 1'b0;
            board_clear <= 1'b1;
            winner      <= 2'b00;
            move_count  <= 4'd0;
            timer       <= 16'd0;
            state       <= StClear;
          end
        end
        StClear: begin
          board_clear <= 1'b0;
          timer       <= 16'd0;
          state       <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer with a behavioural board model and TIMEOUT = 4.
module tb_move_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        x_req, o_req, new_game;
  logic [3:0]  x_pos, o_pos;
  logic        turn;
  logic [17:0] board_state;
  logic        xwin, owin, tie;
  logic [3:0]  position;
  logic        board_clear, x_ack, o_ack, x_rej, o_rej, move_err, game_over;
  logic [1:0]  winner;
  logic [3:0]  move_count;
  logic        board_en;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  move_sequencer #(.TIMEOUT(16'd4)) dut (
    .clk         (clk),
    .reset       (reset),
    .x_req       (x_req),
    .x_pos       (x_pos),
    .o_req       (o_req),
    .o_pos       (o_pos),
    .new_game    (new_game),
    .turn        (turn),
    .board_state (board_state),
    .xwin        (xwin),
    .owin        (owin),
    .tie         (tie),
    .position    (position),
    .board_clear (board_clear),
    .x_ack       (x_ack),
    .o_ack       (o_ack),
    .x_rej       (x_rej),
    .o_rej       (o_rej),
    .move_err    (move_err),
    .game_over   (game_over),
    .winner      (winner),
    .move_count  (move_count)
  );

  // Board register: writes the mover's symbol and flips turn when a move command arrives.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      board_state <= '0;
      turn        <= 1'b0;
    end else if (board_clear) begin
      board_state <= '0;
      turn        <= 1'b0;
    end else if (board_en && position != 4'd0) begin
      board_state[2*position-2 +: 2] <= turn ? 2'b10 : 2'b11;
      turn <= ~turn;
    end
  end

  function automatic logic has_line(input logic [17:0] b, input logic [1:0] s);
    int ln [8][3] = '{'{1,2,3}, '{4,5,6}, '{7,8,9}, '{1,4,7},
                      '{2,5,8}, '{3,6,9}, '{1,5,9}, '{3,5,7}};
    for (int l = 0; l < 8; l++) begin
      if (b[2*ln[l][0]-1 -: 2] == s && b[2*ln[l][1]-1 -: 2] == s && b[2*ln[l][2]-1 -: 2] == s)
        return 1'b1;
    end
    return 1'b0;
  endfunction

  assign xwin = has_line(board_state, 2'b11);
  assign owin = has_line(board_state, 2'b10);
  assign tie  = (&{board_state[17], board_state[15], board_state[13], board_state[11],
                   board_state[9], board_state[7], board_state[5], board_state[3],
                   board_state[1]}) && !xwin && !owin;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in an IDLE cycle; runs one committed move and returns in the following cycle.
  task automatic do_move(input logic is_o, input logic [3:0] p, input logic [3:0] exp_cnt);
    if (is_o) begin o_req = 1'b1; o_pos = p; end
    else begin x_req = 1'b1; x_pos = p; end
    #1;
    chk("rej_on_valid", is_o ? o_rej : x_rej, 0);
    tick();
    chk("issue_pos", position, p);
    tick();
    chk("wait_pos", position, 0);
    tick();
    chk("ack", is_o ? o_ack : x_ack, 1);
    chk("other_ack", is_o ? x_ack : o_ack, 0);
    chk("no_err", move_err, 0);
    x_req = 1'b0;
    o_req = 1'b0;
    tick();
    chk("count", move_count, exp_cnt);
    chk("ack_gone", is_o ? o_ack : x_ack, 0);
  endtask

  initial begin
    reset = 1'b1; board_en = 1'b1; new_game = 1'b0;
    x_req = 1'b1; x_pos = 4'd0; o_req = 1'b0; o_pos = 4'd0;
    #3;
    chk("rst_position", position, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_winner", winner, 0);
    chk("rst_count", move_count, 0);
    chk("rst_clear", board_clear, 0);
    chk("rst_xrej", x_rej, 0);
    #19 reset = 1'b0;
    #1;
    chk("first_cycle_no_rej", x_rej, 0);
    tick();
    chk("rej_pos0", x_rej, 1);
    x_pos = 4'd10; #1;
    chk("rej_pos10", x_rej, 1);
    chk("rej_pos10_nopos", position, 0);
    x_pos = 4'd5; o_req = 1'b1; o_pos = 4'd1; #1;
    chk("both_req_orej", o_rej, 1);
    chk("both_req_xok", x_rej, 0);
    do_move(1'b0, 4'd5, 4'd1);

    o_req = 1'b1; o_pos = 4'd5; #1;
    chk("o_occupied_rej", o_rej, 1);
    chk("o_occupied_nopos", position, 0);
    o_req = 1'b0; x_req = 1'b1; x_pos = 4'd6; #1;
    chk("x_offturn_rej", x_rej, 1);
    // Timer must hold while X is rejected for longer than TIMEOUT cycles.
    repeat (5) begin
      tick();
      chk("hold_rej", x_rej, 1);
      chk("hold_no_forfeit", game_over, 0);
    end
    x_req = 1'b0;
    do_move(1'b1, 4'd4, 4'd2);
    x_req = 1'b1; x_pos = 4'd5; #1;
    chk("x_occupied_rej", x_rej, 1);
    x_req = 1'b0;
    do_move(1'b0, 4'd1, 4'd3);
    do_move(1'b1, 4'd7, 4'd4);
    do_move(1'b0, 4'd2, 4'd5);
    do_move(1'b1, 4'd8, 4'd6);
    do_move(1'b0, 4'd3, 4'd7);
    chk("xwin_over", game_over, 1);
    chk("xwin_winner", winner, 1);

    x_req = 1'b1; x_pos = 4'd6; o_req = 1'b1; o_pos = 4'd9; #1;
    chk("over_xrej", x_rej, 1);
    chk("over_orej", o_rej, 1);
    tick();
    chk("over_held", winner, 1);
    chk("over_nopos", position, 0);
    x_req = 1'b0; o_req = 1'b0; new_game = 1'b1;
    tick();
    new_game = 1'b0;
    chk("clear_pulse", board_clear, 1);
    chk("clear_gameover", game_over, 0);
    chk("clear_count", move_count, 0);
    chk("clear_winner", winner, 0);
    tick();
    chk("clear_one_cycle", board_clear, 0);

    do_move(1'b0, 4'd9, 4'd1);
    tick(); tick(); tick();
    chk("pre_timeout", game_over, 0);
    tick();
    chk("timeout_over", game_over, 1);
    chk("timeout_winner", winner, 1);

    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    tick();
    board_en = 1'b0;
    x_req = 1'b1; x_pos = 4'd9;
    tick();
    chk("err_issue_pos", position, 9);
    tick();
    tick();
    chk("err_pulse", move_err, 1);
    chk("err_no_ack", x_ack, 0);
    x_req = 1'b0;
    tick();
    chk("err_count", move_count, 0);
    chk("err_gone", move_err, 0);
    board_en = 1'b1;

    tick(); tick(); tick();
    x_req = 1'b1; x_pos = 4'd2;
    tick();
    chk("req_beats_timeout", position, 2);
    chk("req_beats_timeout_go", game_over, 0);

    reset = 1'b1; #1;
    chk("midmove_rst_pos", position, 0);
    chk("midmove_rst_ack", x_ack, 0);
    x_req = 1'b0; #2 reset = 1'b0;
    tick(); tick(); tick();
    chk("after_rst_pos", position, 0);
    chk("after_rst_ack", x_ack, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
